pwm: RTL and testbench

PWM -- requirements
Module: pwm

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_channel.sv | 54 +++++
 rtl/pwm.sv | 56 +++++
 tb/tb_pwm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared defaults and selector-width helper for the pwm block
package pwm_pkg;

    localparam int default_pwm_width = 8;
    localparam int default_num_pwm   = 1;

    // Channel-select width; a single channel still gets a 1-bit selector.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one pwm channel: threshold, optional shadow, compare, output flop
// Optional period-boundary threshold update enabled by PWM_SHADOW_EN.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int pwm_width = default_pwm_width
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef PWM_SHADOW_EN
    input  logic                 wrap,
`endif
    input  logic [pwm_width-1:0] cnt,
    input  logic                 wr_en,
    input  logic [pwm_width-1:0] wr_data,
    output logic                 pwm_out
);

    logic [pwm_width-1:0] thr;

`ifdef PWM_SHADOW_EN
    logic [pwm_width-1:0] shadow;

    // A load landing on the wrap edge bypasses the shadow so it is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            thr     <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow <= wr_data;
            end
            if (wrap) begin
                thr <= wr_en ? wr_data : shadow;
            end
            pwm_out <= (cnt < thr);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            thr     <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (wr_en) begin
                thr <= wr_data;
            end
            pwm_out <= (cnt < thr);
        end
    end
`endif

endmodule

// File: rtl/pwm.sv
// rtl/pwm.sv - multi-channel pwm: shared counter, wrap detect, write decode, channels
// Build option PWM_SHADOW_EN defers threshold loads to the period boundary.
module pwm
    import pwm_pkg::*;
#(
    parameter int pwm_width = default_pwm_width,
    parameter int num_pwm   = default_num_pwm
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [pwm_width-1:0]            new_thres,
    input  logic [sel_width(num_pwm)-1:0]   sel_thres,
    input  logic                            set_thres,
    output logic [num_pwm-1:0]              pwm_out
);

    localparam int sel_w = sel_width(num_pwm);

    logic [pwm_width-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef PWM_SHADOW_EN
    // High in the last cycle of a period, so shadows copy as cnt returns to 0.
    logic wrap;
    assign wrap = &cnt;
`endif

    for (genvar i = 0; i < num_pwm; i++) begin : g_chan
        logic wr_en;

        // Selector values past the last channel match nothing and are dropped.
        assign wr_en = set_thres && (sel_thres == sel_w'(i));

        pwm_channel #(
            .pwm_width (pwm_width)
        ) u_channel (
            .clk     (clk),
            .rst     (rst),
`ifdef PWM_SHADOW_EN
            .wrap    (wrap),
`endif
            .cnt     (cnt),
            .wr_en   (wr_en),
            .wr_data (new_thres),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm.sv
// tb/tb_pwm.sv - directed self-checking bench for pwm (4-bit, 4-channel and 3-channel builds)
module tb_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] new_thres;
    logic [1:0] sel_thres;
    logic       set_thres;
    logic [3:0] pwm_out;

    logic [3:0] new3;
    logic [1:0] sel3;
    logic       set3;
    logic [2:0] pwm_out3;

    int total = 0;
    int bad   = 0;
    int tb_cnt = 0;

`ifdef PWM_SHADOW_EN
    localparam bit shadow_en = 1'b1;
`else
    localparam bit shadow_en = 1'b0;
`endif

    always #5 clk = ~clk;

    pwm #(.pwm_width(4), .num_pwm(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .new_thres (new_thres),
        .sel_thres (sel_thres),
        .set_thres (set_thres),
        .pwm_out   (pwm_out)
    );

    pwm #(.pwm_width(4), .num_pwm(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .new_thres (new3),
        .sel_thres (sel3),
        .set_thres (set3),
        .pwm_out   (pwm_out3)
    );

    // Advance one clock; tb_cnt is the counter value the design should now hold.
    task automatic step();
        @(posedge clk);
        if (rst) tb_cnt = 0;
        else     tb_cnt = (tb_cnt + 1) % 16;
        #1;
    endtask

    // Leaves the bench in the cnt==1 cycle, i.e. the first sample of a fresh period.
    task automatic sync_period();
        step();
        while (tb_cnt != 0) step();
        step();
    endtask

    // Output seen with counter value c reflects the compare done at c-1.
    function automatic logic [3:0] exp_vec(input int c, input int t0, input int t1,
                                           input int t2, input int t3);
        int p;
        p = (c + 15) % 16;
        return {p < t3, p < t2, p < t1, p < t0};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (pwm_out !== 4'b0000 || pwm_out3 !== 3'b000) begin
                bad++;
                $display("FAIL reset_hold: got %b/%b want 0000/000", pwm_out, pwm_out3);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (pwm_out !== 4'b0000 || pwm_out3 !== 3'b000) begin
                bad++;
                $display("FAIL reset_idle: cnt=%0d got %b/%b want 0000/000", tb_cnt, pwm_out, pwm_out3);
            end
        end
    endtask

    task automatic test_single();
        int hi;
        logic [3:0] e;
        hi = 0;
        sel_thres = 2'd0; new_thres = 4'd5; set_thres = 1'b1;
        step();
        set_thres = 1'b0;
        sync_period();
        for (int k = 0; k < 16; k++) begin
            e = exp_vec(tb_cnt, 5, 0, 0, 0);
            total++;
            if (pwm_out !== e) begin
                bad++;
                $display("FAIL single_ch0: cnt=%0d got %b want %b", tb_cnt, pwm_out, e);
            end
            hi += int'(pwm_out[0]);
            step();
        end
        total++;
        if (hi != 5) begin
            bad++;
            $display("FAIL single_duty: got %0d high cycles want 5", hi);
        end
    endtask

    task automatic test_multi();
        int vals [4] = '{0, 15, 8, 1};
        int hi [4] = '{0, 0, 0, 0};
        logic [3:0] e;
        set_thres = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel_thres = 2'(i);
            new_thres = 4'(vals[i]);
            step();
        end
        set_thres = 1'b0;
        sync_period();
        for (int k = 0; k < 16; k++) begin
            e = exp_vec(tb_cnt, 0, 15, 8, 1);
            total++;
            if (pwm_out !== e) begin
                bad++;
                $display("FAIL multi_wave: cnt=%0d got %b want %b", tb_cnt, pwm_out, e);
            end
            for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (hi[i] != vals[i]) begin
                bad++;
                $display("FAIL multi_duty ch%0d: got %0d/16 want %0d/16", i, hi[i], vals[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        sel_thres = 2'd1; set_thres = 1'b1;
        new_thres = 4'd3;
        step();
        new_thres = 4'd6;
        step();
        set_thres = 1'b0;
        sync_period();
        for (int k = 0; k < 16; k++) begin
            e = exp_vec(tb_cnt, 0, 6, 8, 1);
            total++;
            if (pwm_out !== e) begin
                bad++;
                $display("FAIL last_write_wins: cnt=%0d got %b want %b", tb_cnt, pwm_out, e);
            end
            step();
        end
    endtask

    task automatic test_midperiod();
        int cur;
        logic [3:0] e;
        cur = shadow_en ? 8 : 12;
        sync_period();
        while (tb_cnt != 4) step();
        sel_thres = 2'd2; new_thres = 4'd12; set_thres = 1'b1;
        step();
        set_thres = 1'b0;
        for (int k = 0; k < 12; k++) begin
            e = exp_vec(tb_cnt, 0, 6, cur, 1);
            total++;
            if (pwm_out !== e) begin
                bad++;
                $display("FAIL midperiod_cur: cnt=%0d got %b want %b", tb_cnt, pwm_out, e);
            end
            step();
        end
        for (int k = 0; k < 16; k++) begin
            e = exp_vec(tb_cnt, 0, 6, 12, 1);
            total++;
            if (pwm_out !== e) begin
                bad++;
                $display("FAIL midperiod_next: cnt=%0d got %b want %b", tb_cnt, pwm_out, e);
            end
            step();
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1;
        set_thres = 1'b1; sel_thres = 2'd0; new_thres = 4'd9;
        set3 = 1'b1; sel3 = 2'd0; new3 = 4'd9;
        step();
        step();
        rst = 1'b0; set_thres = 1'b0; set3 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (pwm_out !== 4'b0000 || pwm_out3 !== 3'b000) begin
                bad++;
                $display("FAIL reset_priority: cnt=%0d got %b/%b want 0000/000", tb_cnt, pwm_out, pwm_out3);
            end
        end
    endtask

    task automatic test_out_of_range();
        int hi;
        logic [3:0] e;
        hi = 0;
        set3 = 1'b1; sel3 = 2'd1; new3 = 4'd4;
        step();
        sel3 = 2'd3; new3 = 4'd7;
        step();
        set3 = 1'b0;
        sync_period();
        for (int k = 0; k < 16; k++) begin
            e = exp_vec(tb_cnt, 0, 4, 0, 0);
            total++;
            if (pwm_out3 !== e[2:0] || pwm_out !== 4'b0000) begin
                bad++;
                $display("FAIL out_of_range: cnt=%0d got %b/%b want %b/0000", tb_cnt, pwm_out3, pwm_out, e[2:0]);
            end
            hi += int'(pwm_out3[1]);
            step();
        end
        total++;
        if (hi != 4) begin
            bad++;
            $display("FAIL out_of_range_duty: got %0d high cycles want 4", hi);
        end
    endtask

    initial begin
        rst = 1'b1;
        new_thres = '0; sel_thres = '0; set_thres = 1'b0;
        new3 = '0; sel3 = '0; set3 = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_midperiod();
        test_reset_priority();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
